// File: rtl/mips_cpu_muldiv_unit.sv
// Iterative multiply/divide unit owning the MIPS HI/LO registers.
// 32 shift-add or restoring-divide iterations bracketed by capture and sign-fixup cycles.
module mips_cpu_muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_write,
    input  logic        lo_write,
    input  logic [31:0] mt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [64:0] acc_q, acc_d;
    logic [31:0] m_q, m_d;
    logic [31:0] a_q, a_d;
    logic [1:0]  op_q, op_d;
    logic        neg_q, neg_d, rneg_q, rneg_d, bzero_q, bzero_d;

    logic        a_neg, b_neg, fix_signs, trial_ok;
    logic [31:0] mag_a, mag_b, quo, rem, trial;
    logic [32:0] sum, rem_sh;
    logic [63:0] prod;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    always_comb begin
        a_neg     = ~op[0] & op_a[31];
        b_neg     = ~op[0] & op_b[31];
        mag_a     = a_neg ? neg32(op_a) : op_a;
        mag_b     = b_neg ? neg32(op_b) : op_b;
        fix_signs = ~op_q[0];
        // Multiply adds into the upper half with a carry into bit 64; divide uses {rem,quot} in [63:0].
        sum       = {1'b0, acc_q[63:32]} + {1'b0, m_q};
        rem_sh    = acc_q[63:31];
        trial_ok  = rem_sh >= {1'b0, m_q};
        trial     = rem_sh[31:0] - m_q;
        prod      = (fix_signs && neg_q) ? neg64(acc_q[63:0]) : acc_q[63:0];
        quo       = (fix_signs && neg_q) ? neg32(acc_q[31:0]) : acc_q[31:0];
        rem       = (fix_signs && rneg_q) ? neg32(acc_q[63:32]) : acc_q[63:32];
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        m_d     = m_q;
        a_d     = a_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        bzero_d = bzero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = op_a;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    bzero_d = (op_b == 32'd0);
                    count_d = 5'd0;
                    state_d = CALC;
                    if (op[1]) begin
                        acc_d = {33'd0, mag_a};
                        m_d   = mag_b;
                    end else begin
                        acc_d = {33'd0, mag_b};
                        m_d   = mag_a;
                    end
                end else begin
                    if (hi_write) hi_d = mt_data;
                    if (lo_write) lo_d = mt_data;
                end
            end
            CALC: begin
                if (op_q[1]) begin
                    if (trial_ok) acc_d = {1'b0, trial, acc_q[30:0], 1'b1};
                    else          acc_d = {1'b0, rem_sh[31:0], acc_q[30:0], 1'b0};
                end else begin
                    if (acc_q[0]) acc_d = {1'b0, sum, acc_q[31:1]};
                    else          acc_d = {1'b0, acc_q[64:1]};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = FINISH;
            end
            FINISH: begin
                if (op_q[1]) begin
                    // Divide by zero forces HI = dividend, LO = all ones.
                    hi_d = bzero_q ? a_q : rem;
                    lo_d = bzero_q ? 32'hFFFF_FFFF : quo;
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 5'd0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else if (clk_enable) begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_enable) begin
            acc_q   <= acc_d;
            m_q     <= m_d;
            a_q     <= a_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            bzero_q <= bzero_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Self-checking bench for mips_cpu_muldiv_unit: directed vectors, corner sequences
// and random operations against an arithmetic reference model.
module tb_mips_cpu_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_enable = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        hi_write = 1'b0;
    logic        lo_write = 1'b0;
    logic [31:0] mt_data = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    always #5 clk = ~clk;

    mips_cpu_muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .start      (start),
        .op         (op),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi_write   (hi_write),
        .lo_write   (lo_write),
        .mt_data    (mt_data),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: MIPS semantics via native 64-bit arithmetic ({hi,lo}).
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (o)
            2'd0: p = sa * sb;
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // mode: 0 plain, 1 start/MT strobes injected while busy, 2 lo_write alongside start,
    // 3 clk_enable toggled every cycle while busy.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int mode, input string name);
        logic [31:0] prev_hi, prev_lo;
        int lat, cyc;
        bit held_ok;
        prev_hi    = hi;
        prev_lo    = lo;
        clk_enable = 1'b1;
        op         = o;
        op_a       = a;
        op_b       = b;
        start      = 1'b1;
        if (mode == 2) begin
            lo_write = 1'b1;
            mt_data  = 32'h0000_BEEF;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start    = 1'b0;
        lo_write = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        op       = 2'($urandom_range(0, 3));
        held_ok  = 1'b1;
        cyc      = 0;
        while (!done && cyc < 200) begin
            if (cyc == 0) begin
                check({name, " busy"}, {63'd0, busy}, 64'd1);
                check({name, " done low"}, {63'd0, done}, 64'd0);
            end
            if (hi !== prev_hi || lo !== prev_lo) held_ok = 1'b0;
            if (mode == 3) clk_enable = ~clk_enable;
            if (mode == 1 && cyc == 5) begin
                start    = 1'b1;
                op       = 2'd3;
                op_a     = $urandom;
                op_b     = $urandom;
                hi_write = 1'b1;
                lo_write = 1'b1;
                mt_data  = 32'hDEAD_BEEF;
            end
            if (mode == 1 && cyc == 6) begin
                start    = 1'b0;
                hi_write = 1'b0;
                lo_write = 1'b0;
            end
            @(posedge clk);
            if (clk_enable) lat++;
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 64'(lat), 64'd34);
        check({name, " hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
        check({name, " lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
        check({name, " busy in done"}, {63'd0, busy}, 64'd0);
        check({name, " hold"}, {63'd0, held_ok}, 64'd1);
        if (mode == 3) begin
            clk_enable = 1'b0;
            @(negedge clk);
            check({name, " done held"}, {63'd0, done}, 64'd1);
            clk_enable = 1'b1;
            @(negedge clk);
            check({name, " done cleared"}, {63'd0, done}, 64'd0);
        end
    endtask

    initial begin
        vec_t tbl[8];
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        tbl[0] = '{2'd0, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1};
        tbl[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{2'd3, 32'hFFFF_FFFF, 32'd16,         32'h0000_000F, 32'h0FFF_FFFF};
        tbl[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
        tbl[5] = '{2'd3, 32'd7,         32'd0,          32'd7,         32'hFFFF_FFFF};
        tbl[6] = '{2'd2, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};
        tbl[7] = '{2'd0, 32'd3,         32'd4,          32'd0,         32'd12};

        repeat (2) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        hi_write = 1'b1;
        mt_data  = 32'h0000_1234;
        @(negedge clk);
        hi_write = 1'b0;
        check("mthi hi", {32'd0, hi}, 64'h1234);
        check("mthi lo", {32'd0, lo}, 64'd0);
        lo_write = 1'b1;
        mt_data  = 32'h0000_5678;
        @(negedge clk);
        lo_write = 1'b0;
        check("mtlo lo", {32'd0, lo}, 64'h5678);
        check("mtlo hi", {32'd0, hi}, 64'h1234);
        hi_write = 1'b1;
        lo_write = 1'b1;
        mt_data  = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_write = 1'b0;
        lo_write = 1'b0;
        check("mt both hi", {32'd0, hi}, 64'hA5A5_A5A5);
        check("mt both lo", {32'd0, lo}, 64'hA5A5_A5A5);

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, 0, $sformatf("vec%0d", i));

        run_op(2'd0, 32'd6, 32'd7, {32'd0, 32'd42}, 1, "ignore busy");
        run_op(2'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 2, "start beats mtlo");
        run_op(2'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 3, "clk_enable");

        hi_write = 1'b1;
        lo_write = 1'b1;
        mt_data  = 32'h5A5A_5A5A;
        @(negedge clk);
        hi_write = 1'b0;
        lo_write = 1'b0;
        op    = 2'd0;
        op_a  = $urandom;
        op_b  = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        check("pre-reset busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("async reset busy", {63'd0, busy}, 64'd0);
        check("async reset done", {63'd0, done}, 64'd0);
        check("async reset hi", {32'd0, hi}, 64'd0);
        check("async reset lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(2'd0, 32'd3, 32'd4, {32'd0, 32'd12}, 0, "mult after reset");

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = $urandom_range(1, 300);
                default: rb = $urandom;
            endcase
            if (i == 0) ra = 32'h8000_0000;
            run_op(ro, ra, rb, model(ro, ra, rb), 0, $sformatf("rand%0d op%0d %h/%h", i, ro, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_cpu_muldiv_unit.md
# mips_cpu_muldiv_unit

Multi-cycle multiply/divide unit that owns the HI and LO architectural registers for the MIPS CPU. It replaces the single-cycle `*`, `/` and `%` operators in the CPU core with a synthesisable iterative engine. The decode logic issues MULT/MULTU/DIV/DIVU requests and MTHI/MTLO writes, stalls on `busy`, and reads `hi`/`lo` for MFHI/MFLO.

## Interface

Parameters:
- none (32-bit datapath fixed)

Ports:
- `clk`  in  1  system clock, single clock domain
- `reset`  in  1  asynchronous, active-high reset
- `clk_enable`  in  1  global clock enable; all state frozen when low
- `start`  in  1  request pulse; sampled only in IDLE
- `op`  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
- `op_a`  in  32  rs operand (multiplicand / dividend)
- `op_b`  in  32  rt operand (multiplier / divisor)
- `hi_write`  in  1  MTHI strobe
- `lo_write`  in  1  MTLO strobe
- `mt_data`  in  32  data for MTHI/MTLO
- `busy`  out  1  high while an operation is in progress (state != IDLE)
- `done`  out  1  one-cycle pulse; `hi`/`lo` hold new result in this cycle
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation

- All updates occur on a `posedge clk` with `clk_enable`=1. Reset overrides everything.
- States: IDLE, CALC, FINISH.
- **IDLE**
  - `start`=1: capture `op`, `op_a`, `op_b`; count=0; go to CALC. Any simultaneous `hi_write`/`lo_write` is ignored.
  - Otherwise, `hi_write` loads `hi` and `lo_write` loads `lo` from `mt_data`. Both may be asserted together.
- **CALC**: exactly 32 iterations, one per enabled edge, count 0..31. At count=31, go to FINISH.
- **FINISH**: apply the sign fixup, write `hi`/`lo`, set `done`, go to IDLE.
- **Operand preparation**
  - Signed ops (MULT, DIV) operate on magnitudes, i.e. the two's-complement absolute value; |0x80000000| = 0x80000000 as unsigned.
  - Unsigned ops use the operands raw.
- **Multiply**: shift-add on a 64-bit accumulator.
  - Each iteration: if multiplier LSB=1, add the multiplicand into accumulator bits [63:32] with a carry into a 65th bit; then shift the accumulator right by 1.
  - Result {hi,lo} = 64-bit product. For signed ops, negate the product in FINISH if the operand signs differ.
- **Divide**: restoring division.
  - Each iteration: shift {rem,quot} left by 1; trial-subtract the divisor; keep the result if it is non-negative and set quotient bit = 1.
  - `lo` = quotient, `hi` = remainder.
  - Signed: the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
- **Boundary cases**
  - Divide by zero (DIV or DIVU): `hi` = original `op_a`, `lo` = 0xFFFFFFFF. This is a forced override in FINISH.
  - DIV 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0. This is the natural result; no trap.
- While busy, `start`, `hi_write` and `lo_write` are ignored. The CPU must stall.
- Operand inputs may change after the `start` edge without affecting the result.
- `hi`/`lo` keep their previous values throughout CALC and FINISH until the FINISH edge.

## Timing

- **Reset values**: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counters 0.
- **Reset mid-operation**: aborts immediately (asynchronous); `hi`/`lo` clear to 0.
- **Latency**: `start` sampled at edge E0.
  - `busy`=1 from after E0 through E33.
  - E33 writes `hi`/`lo`; `done`=1 for the single cycle after E33, with `busy`=0 in that cycle.
  - Total: 34 enabled cycles from the request cycle to the result, identical for all four ops.
- **Back-to-back**: a new `start` may be accepted in the `done` cycle.
- **MTHI/MTLO**: write latency 1 edge; visible on `hi`/`lo` in the next cycle.
- **clk_enable low**: stretches all counts. `done` and `busy` hold their values and are not re-pulsed.
- `busy` is a combinational decode of the registered state. `done` is registered.

## Test plan

- **MULT**: `op_a`=0xFFFFFFFD, `op_b`=5. Expect `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, `done` exactly 34 cycles after the request; then MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **DIV**: −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIVU 0xFFFFFFFF/16 → `lo`=0x0FFFFFFF, `hi`=0xF; DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero**: DIVU 7/0 → `hi`=7, `lo`=0xFFFFFFFF; DIV 0xFFFFFFF9/0 → `hi`=0xFFFFFFF9, `lo`=0xFFFFFFFF.
- **MT writes and priority**: `hi_write` with 0x1234 in IDLE → `hi`=0x1234 next cycle. Then, while busy: assert `hi_write`/`lo_write` and `start` with different operands → all ignored, result unaffected. Then `start` + `lo_write` together in IDLE → `start` wins, `lo` unchanged until `done`.
- **Reset**: assert `reset` asynchronously at count=15 of a MULT → `busy`, `done`, `hi`, `lo` all 0 immediately; a later MULT 3×4 gives `lo`=12, `hi`=0.
- **clk_enable**: toggle `clk_enable` at 50% duty during a DIVU 100/7 → `done` after 34 enabled edges, `lo`=14, `hi`=2, `done` high for exactly one enabled cycle.
